// File: rtl/spi_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_counter_pkg
// Purpose  : Shared types and widths for the SPI counter-link receiver.
// Revision : 1.0 - initial release
// ============================================================================
package spi_counter_pkg;

  localparam int BYTE_W    = 8;
  localparam int COUNTER_W = 14;
  localparam int HI_BITS   = 6;

  // Which byte of the two-byte frame the receiver expects next.
  typedef enum logic [0:0] {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } frame_state_t;

  // A high byte is well formed only if the bits above the counter field are zero.
  function automatic logic frame_hi_ok(input logic [BYTE_W-1:0] b);
    return (b[BYTE_W-1:HI_BITS] == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_counter_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_counter_slave_if
// Purpose  : SPI pin bundle (sclk/mosi/ss/miso) with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_counter_slave_if;

  logic sclk;
  logic mosi;
  logic ss;
  logic miso;

  modport master (output sclk, output mosi, output ss, input miso);
  modport slave  (input sclk, input mosi, input ss, output miso);

endinterface
`default_nettype wire

// File: rtl/spi_slave_byte_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_byte_if
// Purpose  : SPI mode-0 byte engine: input synchronizers, sclk edge detect,
//            MSB-first receive/transmit shift registers and bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_byte_if
  import spi_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  spi_counter_slave_if.slave     bus,
  input  wire logic              i_abort,
  input  wire logic              i_tx_load,
  input  wire logic [BYTE_W-1:0] i_tx_byte,
  output logic                   o_byte_done,
  output logic [BYTE_W-1:0]      o_rx_byte,
  output logic                   o_bit_zero,
  output logic                   o_sclk_edge,
  output logic                   o_ss_high
);

  // Each stage carries {ss, mosi, sclk}.
  logic [2:0]        r_sync [SYNC_STAGES];
  logic              r_sclk_d;
  logic [BYTE_W-1:0] r_rx_shift;
  logic [BYTE_W-1:0] r_tx_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_byte_done;

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_ss_s;
  logic w_rise;
  logic w_fall;

  assign {w_ss_s, w_mosi_s, w_sclk_s} = r_sync[SYNC_STAGES-1];

  // Edges only act on the shift logic while the slave is selected.
  assign w_rise = w_sclk_s & ~r_sclk_d & ~w_ss_s;
  assign w_fall = ~w_sclk_s & r_sclk_d & ~w_ss_s;

  assign o_sclk_edge = w_sclk_s ^ r_sclk_d;
  assign o_ss_high   = w_ss_s;
  assign o_bit_zero  = (r_bit_cnt == 3'd0);
  assign o_byte_done = r_byte_done;
  assign o_rx_byte   = r_rx_shift;
  assign bus.miso    = r_tx_shift[BYTE_W-1];

  // Multi-stage synchronizer for the asynchronous SPI inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {bus.ss, bus.mosi, bus.sclk};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Delayed copy of synced sclk for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sclk_d <= 1'b0;
    else        r_sclk_d <= w_sclk_s;
  end

  // Receive path: sample mosi on rising edges, flag the byte one cycle after bit 8.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_shift  <= '0;
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
    end else if (i_abort || w_ss_s) begin
      r_rx_shift  <= '0;
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= w_rise && (r_bit_cnt == 3'd7);
      if (w_rise) begin
        r_rx_shift <= {r_rx_shift[BYTE_W-2:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
    end
  end

  // Transmit path: reload between bytes so bit 7 is on miso before the first rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_tx_shift <= '0;
    else if (i_tx_load) r_tx_shift <= i_tx_byte;
    else if (w_fall)    r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
  end

endmodule
`default_nettype wire

// File: rtl/spi_counter_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_counter_slave
// Purpose  : Receives the two-byte 14-bit counter frame over SPI, commits it
//            with a valid strobe, echoes the committed value on miso, and
//            discards stalled partial frames after a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module spi_counter_slave
  import spi_counter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  spi_counter_slave_if.slave bus,
  output logic [COUNTER_W-1:0] o_counter,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic               o_timeout
);

  localparam int                IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  frame_state_t         r_state;
  frame_state_t         w_state_nxt;
  logic [HI_BITS-1:0]   r_hi;
  logic [COUNTER_W-1:0] r_counter;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_timeout;
  logic [IDLE_W-1:0]    r_idle_cnt;

  logic              w_byte_done;
  logic [BYTE_W-1:0] w_rx_byte;
  logic              w_bit_zero;
  logic              w_sclk_edge;
  logic              w_ss_high;
  logic              w_byte_ok;
  logic              w_active;
  logic              w_timeout;
  logic              w_tx_load;
  logic [BYTE_W-1:0] w_tx_byte;
  logic              w_hi_load;
  logic              w_commit;
  logic              w_frame_err;

  spi_slave_byte_if #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .i_abort     (w_timeout),
    .i_tx_load   (w_tx_load),
    .i_tx_byte   (w_tx_byte),
    .o_byte_done (w_byte_done),
    .o_rx_byte   (w_rx_byte),
    .o_bit_zero  (w_bit_zero),
    .o_sclk_edge (w_sclk_edge),
    .o_ss_high   (w_ss_high)
  );

  // A deselect in the same cycle as byte completion cancels the byte.
  assign w_byte_ok = w_byte_done & ~w_ss_high;
  assign w_active  = ~w_bit_zero | (r_state == WAIT_LOW);
  // byte_done always follows an edge that cleared idle_cnt, so it can never coincide with expiry.
  assign w_timeout = w_active & ~w_sclk_edge & ~w_byte_done & ~w_ss_high &
                     (r_idle_cnt == C_IDLE_LAST);
  assign w_tx_load = w_bit_zero & ~w_sclk_edge;

  assign o_counter   = r_counter;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_timeout   = r_timeout;

  // Frame state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= WAIT_HIGH;
    else        r_state <= w_state_nxt;
  end

  // Frame sequencing: high byte, then low byte; deselect and timeout restart the frame.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ss_high || w_timeout) begin
      w_state_nxt = WAIT_HIGH;
    end else if (w_byte_done) begin
      case (r_state)
        WAIT_HIGH: if (frame_hi_ok(w_rx_byte)) w_state_nxt = WAIT_LOW;
        WAIT_LOW:  w_state_nxt = WAIT_HIGH;
        default:   w_state_nxt = WAIT_HIGH;
      endcase
    end
  end

  // Per-state actions and the byte offered to the transmitter.
  always_comb begin
    w_hi_load   = 1'b0;
    w_commit    = 1'b0;
    w_frame_err = 1'b0;
    w_tx_byte   = {{(BYTE_W-HI_BITS){1'b0}}, r_counter[COUNTER_W-1:BYTE_W]};
    case (r_state)
      WAIT_HIGH: begin
        w_hi_load   = w_byte_ok & frame_hi_ok(w_rx_byte);
        w_frame_err = w_byte_ok & ~frame_hi_ok(w_rx_byte);
      end
      WAIT_LOW: begin
        w_commit  = w_byte_ok;
        w_tx_byte = r_counter[BYTE_W-1:0];
      end
      default: ;
    endcase
  end

  // Idle watchdog: runs only while a frame is in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                  r_idle_cnt <= '0;
    else if (w_ss_high || w_sclk_edge || !w_active || w_timeout) r_idle_cnt <= '0;
    else                                                         r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
  end

  // High-byte holding register, committed counter and event strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi        <= '0;
      r_counter   <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_hi_load) r_hi      <= w_rx_byte[HI_BITS-1:0];
      if (w_commit)  r_counter <= {r_hi, w_rx_byte};
      r_valid     <= w_commit;
      r_frame_err <= w_frame_err;
      r_timeout   <= w_timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_counter_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_counter_slave
// Purpose  : Self-checking bench for spi_counter_slave with a frame-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_counter_slave;

  localparam int TIMEOUT_CYCLES = 1000;
  localparam int SYNC_STAGES    = 2;

  logic        clk;
  logic        reset;
  logic [13:0] o_counter;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_timeout;

  spi_counter_slave_if bus ();

  spi_counter_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_counter   (o_counter),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_timeout   (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Observed pulse counts and their cycle stamps.
  int n_valid = 0, n_err = 0, n_tmo = 0;
  int valid_cyc = 0, tmo_cyc = 0;
  int last_rise_cyc = 0;

  // Reference model: committed value, pending high byte, expected pulse counts.
  logic [13:0] m_cnt;
  logic        m_low;
  logic [5:0]  m_hi;
  int          e_valid = 0, e_err = 0, e_tmo = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (o_valid === 1'b1)     begin n_valid++; valid_cyc = cyc; end
    if (o_frame_err === 1'b1) n_err++;
    if (o_timeout === 1'b1)   begin n_tmo++; tmo_cyc = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Master side: n MSB-first bits of b, sampling miso just before each rising edge.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = b[7-i];
      tick(5);
      got[7-i] = bus.miso;
      bus.sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(5);
      bus.sclk = 1'b0;
    end
  endtask

  // One full byte with the echoed miso byte checked against the model.
  task automatic send_byte(input logic [7:0] b);
    logic [7:0] got;
    logic [7:0] exp_miso;
    exp_miso = m_low ? m_cnt[7:0] : {2'b00, m_cnt[13:8]};
    spi_bits(b, 8, got);
    check("miso_byte", {24'd0, got}, {24'd0, exp_miso});
    if (!m_low) begin
      if (b[7:6] != 2'b00) e_err++;
      else begin m_hi = b[5:0]; m_low = 1'b1; end
    end else begin
      m_cnt = {m_hi, b};
      m_low = 1'b0;
      e_valid++;
    end
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    send_byte(lo);
    tick(6);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_counter"}, {18'd0, o_counter}, {18'd0, m_cnt});
    check({tag, "_valids"},  n_valid, e_valid);
    check({tag, "_errs"},    n_err,   e_err);
    check({tag, "_tmos"},    n_tmo,   e_tmo);
  endtask

  initial begin
    logic [7:0] junk;
    logic [7:0] hi, lo;
    int base, t0, waited;

    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.ss   = 1'b0;
    reset    = 1'b0;
    m_cnt    = '0;
    m_low    = 1'b0;
    m_hi     = '0;

    // Reset values.
    tick(3);
    check("rst_counter", {18'd0, o_counter}, 32'd0);
    check("rst_valid",   {31'd0, o_valid},     32'd0);
    check("rst_err",     {31'd0, o_frame_err}, 32'd0);
    check("rst_tmo",     {31'd0, o_timeout},   32'd0);
    check("rst_miso",    {31'd0, bus.miso},    32'd0);
    reset = 1'b1;
    tick(3);

    // Basic frame and commit latency.
    send_frame(8'h00, 8'h2A);
    check_state("f002a");
    check("valid_latency", valid_cyc - last_rise_cyc, SYNC_STAGES + 2);

    // Extreme values; second frame echoes 0x3F,0xFF on miso.
    send_frame(8'h3F, 8'hFF);
    check_state("f3fff");
    send_frame(8'h00, 8'h00);
    check_state("f0000");

    // Malformed high byte is rejected, next frame is clean.
    send_byte(8'hC1);
    tick(6);
    check_state("badhi");
    send_frame(8'h01, 8'h02);
    check_state("f0102");

    // Random frames, some with malformed high bytes and repeated values.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_byte({2'($urandom_range(1, 3)), 6'($urandom)});
        tick(3);
      end
      hi = 8'($urandom_range(0, 63));
      lo = 8'($urandom);
      send_frame(hi, lo);
      if (k == 4) send_frame(hi, lo);
    end
    check_state("random");

    // High byte only, then silence: partial frame discarded after the timeout.
    send_byte(8'h12);
    base = n_tmo;
    t0 = cyc;
    waited = 0;
    while (n_tmo == base && waited < TIMEOUT_CYCLES + 200) begin
      tick(1);
      waited++;
    end
    e_tmo++;
    m_low = 1'b0;
    check("tmo_count", n_tmo, e_tmo);
    check("tmo_window",
          {31'd0, ((tmo_cyc - t0) >= TIMEOUT_CYCLES) &&
                  ((tmo_cyc - t0) <= TIMEOUT_CYCLES + SYNC_STAGES + 4)}, 32'd1);
    tick(5);
    check_state("after_tmo");
    send_frame(8'h05, 8'h06);
    check_state("f0506");

    // Deselect mid low byte: frame restarts silently.
    send_byte(8'h2B);
    spi_bits(8'hAA, 4, junk);
    bus.ss = 1'b1;
    tick(20);
    m_low = 1'b0;
    bus.ss = 1'b0;
    tick(5);
    send_frame(8'h01, 8'h00);
    check_state("f0100");

    // Asynchronous reset in the middle of a low byte.
    send_byte(8'h15);
    spi_bits(8'hAA, 4, junk);
    reset = 1'b0;
    #2;
    check("mid_rst_counter", {18'd0, o_counter}, 32'd0);
    check("mid_rst_valid",   {31'd0, o_valid},     32'd0);
    check("mid_rst_err",     {31'd0, o_frame_err}, 32'd0);
    check("mid_rst_tmo",     {31'd0, o_timeout},   32'd0);
    check("mid_rst_miso",    {31'd0, bus.miso},    32'd0);
    m_cnt = '0;
    m_low = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    send_frame(8'h00, 8'h07);
    check_state("f0007");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
